// File: rtl/prog_loader.sv
// Program loader: streams 16 host bytes into a 16x8 program RAM, optionally
// verifies a trailing two's-complement checksum byte, and holds the CPU core
// in reset until a load completes cleanly.
module prog_loader #(
   parameter bit CHK_EN = 1'b1
) (
   input  logic       clk,
   input  logic       n_reset,
   input  logic       load_en,
   input  logic       ser_valid,
   input  logic [7:0] ser_data,
   output logic       ser_ready,
   input  logic [3:0] Adr,
   output logic [3:0] Instr,
   output logic [3:0] Im,
   output logic       cpu_n_reset,
   output logic       load_err
);

   typedef enum logic [2:0] {
      S_RUN     = 3'd0,
      S_LOAD    = 3'd1,
      S_CHECK   = 3'd2,
      S_RELEASE = 3'd3,
      S_ERROR   = 3'd4
   } state_t;

   state_t           state, state_nx;
   logic [15:0][7:0] mem;
   logic [3:0]       wr_ptr;
   logic [7:0]       sum;
   logic [7:0]       chk_exp;
   logic             load_en_q;
   logic             rise, fall, xfer;

   // load_en_q resets high so a level already asserted at reset release is not a rise
   assign rise      = load_en & ~load_en_q;
   assign fall      = ~load_en & load_en_q;
   assign ser_ready = (state == S_LOAD) || (state == S_CHECK);
   assign xfer      = ser_valid & ser_ready;
   assign chk_exp   = ~sum + 8'd1;

   // Next-state decode; an abort on load_en fall takes priority over any transfer
   always_comb begin
      state_nx = state;
      case (state)
         S_RUN:     if (rise) state_nx = S_LOAD;
         S_LOAD: begin
            if (fall)
               state_nx = S_ERROR;
            else if (xfer && wr_ptr == 4'd15)
               state_nx = CHK_EN ? S_CHECK : S_RELEASE;
         end
         S_CHECK: begin
            if (fall)
               state_nx = S_ERROR;
            else if (xfer)
               state_nx = (ser_data == chk_exp) ? S_RELEASE : S_ERROR;
         end
         S_RELEASE: state_nx = S_RUN;
         S_ERROR:   if (rise) state_nx = S_LOAD;
         default:   state_nx = S_RUN;
      endcase
   end

   // Zero-latency program fetch, gated to zero whenever the CPU is not running
   always_comb begin
      Instr = '0;
      Im    = '0;
      if (state == S_RUN) begin
         Instr = mem[Adr][7:4];
         Im    = mem[Adr][3:0];
      end
   end

   // State, program RAM, running checksum and registered CPU reset / error flag
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state       <= S_RUN;
         mem         <= '0;
         wr_ptr      <= '0;
         sum         <= '0;
         load_err    <= 1'b0;
         cpu_n_reset <= 1'b0;
         load_en_q   <= 1'b1;
      end else begin
         state       <= state_nx;
         load_en_q   <= load_en;
         cpu_n_reset <= (state_nx == S_RUN);
         if (state_nx == S_LOAD && state != S_LOAD) begin
            wr_ptr   <= '0;
            sum      <= '0;
            load_err <= 1'b0;
         end else if (state == S_LOAD && xfer && !fall) begin
            mem[wr_ptr] <= ser_data;
            sum         <= sum + ser_data;
            wr_ptr      <= wr_ptr + 4'd1;
         end
         if (state_nx == S_ERROR && state != S_ERROR)
            load_err <= 1'b1;
      end
   end

endmodule
